// File: rtl/npu_mac_array_if.sv
// Stream and control bundle for npu_mac_array: input beats, result stream,
// layer control and argmax status. Clock and reset stay outside as plain ports.
interface npu_mac_array_if #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 16,
  parameter int KW    = 10
);
  logic                   START;
  logic [KW-1:0]          K_LEN;
  logic [7:0]             N_GROUPS;
  logic                   RELU_EN;
  logic                   IN_VALID;
  logic                   IN_READY;
  logic [DW-1:0]          IN_X;
  logic [LANES*DW-1:0]    IN_W;
  logic [LANES*DW-1:0]    IN_BIAS;
  logic                   OUT_VALID;
  logic                   OUT_READY;
  logic [ACC_W-1:0]       OUT_DATA;
  logic                   OUT_LAST;
  logic                   BUSY;
  logic                   DONE;
  logic [ACC_W-1:0]       MAX_VAL;
  logic [7:0]             MAX_IDX;

  modport master (
    output START, K_LEN, N_GROUPS, RELU_EN, IN_VALID, IN_X, IN_W, IN_BIAS, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_DATA, OUT_LAST, BUSY, DONE, MAX_VAL, MAX_IDX
  );

  modport slave (
    input  START, K_LEN, N_GROUPS, RELU_EN, IN_VALID, IN_X, IN_W, IN_BIAS, OUT_READY,
    output IN_READY, OUT_VALID, OUT_DATA, OUT_LAST, BUSY, DONE, MAX_VAL, MAX_IDX
  );
endinterface

// File: rtl/npu_mac_array.sv
// LANES-wide signed MAC array with per-lane bias, optional ReLU, layer argmax,
// and a sequencer that serialises each group's lane results over a valid/ready stream.
module npu_mac_array #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 16,
  parameter int KW    = 10,
  parameter int SAT   = 1
) (
  input logic CLKEXT,
  input logic RST_N,
  npu_mac_array_if.slave bus
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_FINISH} state_t;

  state_t                  state;
  logic [KW-1:0]           k_len_r;
  logic [7:0]              n_groups_r;
  logic                    relu_r;
  logic [KW-1:0]           beat;
  logic [7:0]              group;
  logic [LW-1:0]           lane;
  logic signed [ACC_W-1:0] acc [LANES];

  logic                    out_valid_r;
  logic signed [ACC_W-1:0] out_data_r;
  logic                    out_last_r;
  logic                    done_r;
  logic signed [ACC_W-1:0] max_val_r;
  logic [7:0]              max_idx_r;

  logic signed [2*DW-1:0]  prod    [LANES];
  logic signed [ACC_W-1:0] addend  [LANES];
  logic signed [ACC_W-1:0] base    [LANES];
  logic signed [ACC_W:0]   sum     [LANES];
  logic signed [ACC_W-1:0] acc_nxt [LANES];

  logic [LW-1:0]           lane_nxt;
  logic                    last_lane;
  logic                    last_group;
  logic                    last_beat;
  logic [7:0]              cur_idx;

  function automatic logic signed [ACC_W-1:0] post_act(input logic signed [ACC_W-1:0] v,
                                                       input logic en);
    return (en && v < 0) ? '0 : v;
  endfunction

  // One widened add per lane; the carry-out disagreeing with the sign bit marks overflow.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      prod[i]   = $signed(bus.IN_X) * $signed(bus.IN_W[i*DW +: DW]);
      addend[i] = ACC_W'(prod[i]);
      base[i]   = (beat == '0) ? ACC_W'($signed(bus.IN_BIAS[i*DW +: DW])) : acc[i];
      sum[i]    = {base[i][ACC_W-1], base[i]} + {addend[i][ACC_W-1], addend[i]};
      if (SAT != 0 && sum[i][ACC_W] != sum[i][ACC_W-1])
        acc_nxt[i] = sum[i][ACC_W] ? ACC_MIN : ACC_MAX;
      else
        acc_nxt[i] = sum[i][ACC_W-1:0];
    end
  end

  always_comb begin
    lane_nxt   = lane + LW'(1);
    last_lane  = (lane == LW'(LANES - 1));
    last_group = (group == n_groups_r - 8'd1);
    last_beat  = (beat == k_len_r - KW'(1));
    cur_idx    = 8'((32'(group) * LANES) + 32'(lane));
  end

  always_ff @(posedge CLKEXT or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      k_len_r     <= '0;
      n_groups_r  <= '0;
      relu_r      <= 1'b0;
      beat        <= '0;
      group       <= '0;
      lane        <= '0;
      for (int unsigned i = 0; i < LANES; i++) acc[i] <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      done_r      <= 1'b0;
      max_val_r   <= ACC_MIN;
      max_idx_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.START) begin
            k_len_r    <= (bus.K_LEN == '0) ? KW'(1) : bus.K_LEN;
            n_groups_r <= bus.N_GROUPS;
            relu_r     <= bus.RELU_EN;
            max_val_r  <= ACC_MIN;
            max_idx_r  <= '0;
            beat       <= '0;
            group      <= '0;
            lane       <= '0;
            if (bus.N_GROUPS == 8'd0) begin
              state  <= S_FINISH;
              done_r <= 1'b1;
            end else begin
              state <= S_ACCUM;
            end
          end
        end

        S_ACCUM: begin
          if (bus.IN_VALID) begin
            for (int unsigned i = 0; i < LANES; i++) acc[i] <= acc_nxt[i];
            if (last_beat) begin
              // Lane 0 result is taken from the freshly summed value so it is valid next cycle.
              beat        <= '0;
              lane        <= '0;
              state       <= S_DRAIN;
              out_valid_r <= 1'b1;
              out_data_r  <= post_act(acc_nxt[0], relu_r);
              out_last_r  <= (LANES == 1) && last_group;
            end else begin
              beat <= beat + KW'(1);
            end
          end
        end

        S_DRAIN: begin
          if (bus.OUT_READY) begin
            if (out_data_r > max_val_r) begin
              max_val_r <= out_data_r;
              max_idx_r <= cur_idx;
            end
            if (last_lane) begin
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              lane        <= '0;
              if (last_group) begin
                state  <= S_FINISH;
                done_r <= 1'b1;
              end else begin
                group <= group + 8'd1;
                state <= S_ACCUM;
              end
            end else begin
              lane       <= lane_nxt;
              out_data_r <= post_act(acc[lane_nxt], relu_r);
              out_last_r <= (lane_nxt == LW'(LANES - 1)) && last_group;
            end
          end
        end

        S_FINISH: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.IN_READY  = (state == S_ACCUM);
  assign bus.BUSY      = (state != S_IDLE);
  assign bus.OUT_VALID = out_valid_r;
  assign bus.OUT_DATA  = out_data_r;
  assign bus.OUT_LAST  = out_last_r;
  assign bus.DONE      = done_r;
  assign bus.MAX_VAL   = max_val_r;
  assign bus.MAX_IDX   = max_idx_r;

endmodule

// File: doc/npu_mac_array.md
Name: npu_mac_array

Overview:
- Parametrised successor to the fixed two-MAC NPU datapath.
- Contains LANES signed MAC lanes fed by one broadcast activation stream, with per-lane bias.
- Each lane has optional ReLU, and a running argmax is kept across a whole layer.
- An internal sequencer runs N_GROUPS neuron groups of K_LEN terms each, then serialises lane results over a valid/ready output stream.

Parameters:
LANES, 4, number of parallel MAC lanes (neurons per group), >=1
DW, 8, signed width of activations, weights and bias
ACC_W, 16, signed accumulator and result width, >=2*DW
KW, 10, width of K_LEN term counter
SAT, 1, 1 = saturating accumulate, 0 = two's-complement wrap

Ports:
CLKEXT  in  1  clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  begin layer; honoured only in IDLE
K_LEN  in  KW  terms per neuron; sampled at START; 0 treated as 1
N_GROUPS  in  8  neuron groups per layer; sampled at START
RELU_EN  in  1  sampled at START; 1 = clamp negative results to 0
IN_VALID  in  1  input beat valid
IN_READY  out  1  input beat accepted when IN_VALID&IN_READY
IN_X  in  DW  signed activation, broadcast to all lanes
IN_W  in  LANES*DW  signed weights, lane i at [i*DW +: DW]
IN_BIAS  in  LANES*DW  signed biases; sampled on first beat of each group only
OUT_VALID  out  1  result valid
OUT_READY  in  1  result consumed when OUT_VALID&OUT_READY
OUT_DATA  out  ACC_W  signed lane result
OUT_LAST  out  1  high with the final result of the layer
BUSY  out  1  high whenever state != IDLE
DONE  out  1  one-cycle pulse at layer end
MAX_VAL  out  ACC_W  largest post-ReLU result of the layer
MAX_IDX  out  8  global neuron index of MAX_VAL (group*LANES+lane)

Behaviour:
- Reset (async, RST_N=0): state=IDLE.
  - IN_READY, OUT_VALID, OUT_LAST, BUSY, DONE = 0.
  - OUT_DATA = 0, MAX_IDX = 0, MAX_VAL = most-negative (0x8000 for ACC_W=16).
  - Accumulators, counters and lane pointer cleared.
- State IDLE, on START=1:
  - Latch K_LEN, N_GROUPS, RELU_EN.
  - Set MAX_VAL = most-negative and MAX_IDX = 0.
  - If N_GROUPS=0, go to FINISH; otherwise go to ACCUM with beat=0, group=0.
- State ACCUM:
  - IN_READY=1 combinationally, in this state only.
  - Per accepted beat, each lane computes p = IN_X*W_i as a signed DW x DW product, sign-extended to ACC_W.
  - Beat 0: acc_i = sext(BIAS_i) + p.
  - Other beats: acc_i = acc_i + p.
  - With SAT=1, each addition clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; clamping is applied per addition, not only at the end.
  - On acceptance of beat K_LEN-1 (cycle t), go to DRAIN with lane=0; OUT_VALID=1 from cycle t+1.
  - IN_VALID=0 stalls with no state change.
- State DRAIN:
  - OUT_DATA = RELU_EN ? max(acc_lane, 0) : acc_lane; lanes are emitted in order 0..LANES-1.
  - While OUT_VALID & !OUT_READY, OUT_DATA and OUT_LAST stay stable.
  - On each handshake, compare the result to MAX_VAL. Update only when strictly greater, so ties keep the earliest index.
  - After lane LANES-1 is accepted: if group < N_GROUPS-1, increment group and return to ACCUM (IN_READY=1 next cycle, OUT_VALID=0); otherwise go to FINISH.
  - OUT_LAST=1 only for lane LANES-1 of the last group.
- State FINISH:
  - DONE=1 for exactly one cycle, then IDLE.
  - MAX_VAL and MAX_IDX are valid from the DONE cycle and held until the next START.
  - DONE and the final output handshake are never in the same cycle.
- START while BUSY is ignored, and parameter inputs are not resampled.
- Throughput per group: K_LEN input cycles plus at least LANES output cycles; the input is stalled during DRAIN.
- MAX_IDX wraps modulo 256 when N_GROUPS*LANES > 256.

Test Plan:
1. Dot product, ReLU off.
   - Setup: LANES=4, K_LEN=3, N_GROUPS=1, X = 1,2,3.
   - W per lane = {1,-1,2,0} held constant; BIAS = {5,0,-10,0}.
   - Required: OUT_DATA = 11, -6, 2, 0; OUT_LAST on the 4th result; DONE one cycle later; MAX_VAL=11, MAX_IDX=0.
2. Same stimulus, RELU_EN=1 -> OUT_DATA = 11, 0, 2, 0; MAX_VAL=11, MAX_IDX=0.
3. Saturation, SAT=1, K_LEN=4.
   - X=127, W=127, BIAS=127 -> 32767.
   - X=-128, W=127, BIAS=-128 -> -32768 (with RELU_EN=0).
4. Backpressure: hold OUT_READY=0 for 5 cycles on lane 1 -> OUT_DATA stable, IN_READY=0 throughout, no lost or duplicated results; 4 handshakes total.
5. Two-group tie.
   - Setup: N_GROUPS=2; lane 1 yields 20 in both groups; all other lanes are below 20.
   - Required: 8 results, MAX_VAL=20, MAX_IDX=1; IN_READY reasserts the cycle after group 0's last handshake.
6. Reset and edge cases.
   - RST_N=0 after 2 ACCUM beats -> all outputs at reset values immediately; a subsequent full run of case 1 is correct.
   - N_GROUPS=0 -> DONE the cycle after the START cycle, no OUT_VALID, MAX_VAL=-32768.
